// File: rtl/mango_pkg.sv
// Shared pipeline-control definitions: exception codes, CP0 bit positions and vector offsets.
package mango_pkg;

    localparam int EXCT_W = 5;

    typedef enum logic [EXCT_W-1:0] {
        ExcT_Intr = 5'h00,
        ExcT_Mod  = 5'h01,
        ExcT_TLBL = 5'h02,
        ExcT_TLBS = 5'h03,
        ExcT_AdEL = 5'h04,
        ExcT_AdES = 5'h05,
        ExcT_Sys  = 5'h08,
        ExcT_Bp   = 5'h09,
        ExcT_RI   = 5'h0a,
        ExcT_CpU  = 5'h0b,
        ExcT_Ov   = 5'h0c,
        ExcT_Tr   = 5'h0d,
        ExcT_TLBR = 5'h10,
        ExcT_ERET = 5'h11
    } exc_type_e;

    // Status / Cause bit positions
    localparam int BEV_BIT = 22;
    localparam int EXL_BIT = 1;
    localparam int ERL_BIT = 2;
    localparam int IV_BIT  = 23;

    localparam logic [31:0] OFS_GENEXC = 32'h0000_0180;
    localparam logic [31:0] OFS_SPINTR = 32'h0000_0200;
    localparam logic [31:0] OFS_TLBR   = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_redirect_if.sv
// Bundle between the pipeline controller and the datapath / CP0 / fetch stage.
interface pipe_ctrl_redirect_if
    import mango_pkg::*;
#(
    parameter int NSTAGE = 5,
    parameter int ADDR_W = 32
) ();
    logic [NSTAGE-1:0] stallreq;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              exc_flag;
    logic [EXCT_W-1:0] exc_type;
    logic [ADDR_W-1:0] cp0_EPC;
    logic [ADDR_W-1:0] cp0_ErrorEPC;
    logic [31:0]       cp0_Status;
    logic [31:0]       cp0_Cause;
    logic              redir_valid;
    logic              redir_ready;
    logic [ADDR_W-1:0] redir_pc;
    logic              stall_timeout;

    // master is the controller; slave is the surrounding pipeline
    modport master (
        input  stallreq, exc_flag, exc_type, cp0_EPC, cp0_ErrorEPC, cp0_Status, cp0_Cause,
        input  redir_ready,
        output stall, flush, redir_valid, redir_pc, stall_timeout
    );

    modport slave (
        output stallreq, exc_flag, exc_type, cp0_EPC, cp0_ErrorEPC, cp0_Status, cp0_Cause,
        output redir_ready,
        input  stall, flush, redir_valid, redir_pc, stall_timeout
    );
endinterface

// File: rtl/exc_vector_sel.sv
// Combinational exception / ERET target selection from CP0 state.
module exc_vector_sel
    import mango_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] NML_BASE = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] BTS_BASE = ADDR_W'(32'hBFC0_0200),
    parameter int                HAS_TLB  = 0
) (
    input  logic [EXCT_W-1:0] i_exc_type,
    input  logic [ADDR_W-1:0] i_epc,
    input  logic [ADDR_W-1:0] i_error_epc,
    input  logic              i_bev,
    input  logic              i_exl,
    input  logic              i_erl,
    input  logic              i_iv,
    output logic [ADDR_W-1:0] o_vector
);
    logic [ADDR_W-1:0] w_base;

    always_comb begin
        w_base   = i_bev ? BTS_BASE : NML_BASE;
        o_vector = w_base + ADDR_W'(OFS_GENEXC);
        case (i_exc_type)
            ExcT_Intr: o_vector = w_base + (i_iv ? ADDR_W'(OFS_SPINTR) : ADDR_W'(OFS_GENEXC));
            // Without a TLB the refill falls through to the general vector
            ExcT_TLBR: begin
                if (HAS_TLB != 0) begin
                    o_vector = w_base + (i_exl ? ADDR_W'(OFS_GENEXC) : ADDR_W'(OFS_TLBR));
                end
            end
            ExcT_ERET: o_vector = i_erl ? i_error_epc : i_epc;
            default:   ;
        endcase
    end
endmodule

// File: rtl/pipe_ctrl_redirect.sv
// Pipeline stall/flush generation, registered redirect handshake to fetch and stall watchdog.
module pipe_ctrl_redirect
    import mango_pkg::*;
#(
    parameter int                NSTAGE    = 5,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] NML_BASE  = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] BTS_BASE  = ADDR_W'(32'hBFC0_0200),
    parameter int                HAS_TLB   = 0,
    parameter int                STALL_MAX = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_ctrl_redirect_if.master  bus
);
    localparam int CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STALL_MAX);

    ctrl_state_e       r_state;
    ctrl_state_e       w_state_next;
    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout;
    logic [ADDR_W-1:0] w_vector;
    logic [NSTAGE-1:0] w_run_stall;
    logic [NSTAGE-1:0] w_run_flush;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_flush;
    logic              w_unused;

    assign w_unused = &{1'b0, bus.cp0_Status, bus.cp0_Cause};

    // Stage gi holds when some request sits at or above it; IF and ID always hold together.
    // The bubble goes into the first stage above the held block.
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
        localparam int LO = (gi <= 1) ? 0 : gi;
        assign w_run_stall[gi] = |bus.stallreq[NSTAGE-1:LO];
        if (gi == 0) begin : g_first
            assign w_run_flush[gi] = 1'b0;
        end else begin : g_rest
            assign w_run_flush[gi] = w_run_stall[gi-1] & ~w_run_stall[gi];
        end
    end

    exc_vector_sel #(
        .ADDR_W   (ADDR_W),
        .NML_BASE (NML_BASE),
        .BTS_BASE (BTS_BASE),
        .HAS_TLB  (HAS_TLB)
    ) u_exc_vector_sel (
        .i_exc_type  (bus.exc_type),
        .i_epc       (bus.cp0_EPC),
        .i_error_epc (bus.cp0_ErrorEPC),
        .i_bev       (bus.cp0_Status[BEV_BIT]),
        .i_exl       (bus.cp0_Status[EXL_BIT]),
        .i_erl       (bus.cp0_Status[ERL_BIT]),
        .i_iv        (bus.cp0_Cause[IV_BIT]),
        .o_vector    (w_vector)
    );

    always_comb begin
        w_state_next = r_state;
        w_stall      = w_run_stall;
        w_flush      = w_run_flush;
        if (rst) begin
            w_state_next = ST_RUN;
            w_stall      = '0;
            w_flush      = '1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.exc_flag) begin
                        w_state_next = ST_REDIR;
                        w_stall      = '0;
                        w_flush      = '1;
                    end
                end
                ST_REDIR: begin
                    // Fetch waits for the new PC while everything behind it drains
                    w_stall = NSTAGE'(1);
                    w_flush = ~NSTAGE'(1);
                    if (bus.redir_ready) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_RUN && bus.exc_flag) begin
                r_pc    <= w_vector;
                r_valid <= 1'b1;
            end else if (r_state == ST_REDIR && bus.redir_ready) begin
                r_valid <= 1'b0;
            end
            if (r_state == ST_RUN) begin
                if (|w_stall) begin
                    r_cnt <= (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
                end else begin
                    r_cnt <= '0;
                end
            end
            // Compares the current count, so the flag trails the counter by one cycle
            r_timeout <= (r_cnt == CNT_SAT);
        end
    end

    assign bus.stall         = w_stall;
    assign bus.flush         = w_flush;
    assign bus.redir_valid   = r_valid;
    assign bus.redir_pc      = r_pc;
    assign bus.stall_timeout = r_timeout;
endmodule
